ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- N_RD, 3: number of read requesters (mm2s_0..2).
- AXI_WIDTH, 128: memory word width in bits.
- AXI_ADDR_WIDTH, 32: byte address width.
- MAX_BURST, 16: maximum consecutive grants to one owner.
- Derived: LSB = clog2(AXI_WIDTH)-3; AW = AXI_ADDR_WIDTH-LSB.

REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.

REQ-003 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1: clock.
- rstn, in, 1: async active-low reset.
- rd_req, in, N_RD: read requests.
- rd_addr, in, N_RD x AW: word addresses.
- rd_gnt, out, N_RD: read grant, one-hot or zero.
- rd_vld, out, N_RD: read data valid per requester.
- rd_data, out, AXI_WIDTH: shared read data.
- wr_req, in, 1: write request.
- wr_addr, in, AW: write word address.
- wr_data, in, AXI_WIDTH: write data.
- wr_strb, in, AXI_WIDTH/8: byte strobes.
- wr_gnt, out, 1: write grant.
- mem_ren, out, 1: memory read enable.
- mem_wen, out, 1: memory write enable.
- mem_addr, out, AW: memory word address.
- mem_wdata, out, AXI_WIDTH: memory write data.
- mem_strb, out, AXI_WIDTH/8: memory byte strobes.
- mem_rdata, in, AXI_WIDTH: memory read data, valid the cycle after mem_ren.

Function
REQ-004 The arbiter SHALL arbitrate N_REQ = N_RD+1 requesters, with index N_RD being the writer, onto one single-port memory.

REQ-005 At most one of rd_gnt/wr_gnt SHALL be high per cycle, and mem_ren and mem_wen SHALL never be high together.

REQ-006 A grant SHALL be combinational in the same cycle as the request; a transfer completes on any cycle where req and gnt are both high.

REQ-007 Requesters SHALL hold req and address/data stable until granted; an unserved req SHALL never be dropped by the arbiter.

REQ-008 mem_addr/mem_wdata/mem_strb SHALL equal the granted requester's fields, and mem_ren (reader granted) or mem_wen (writer granted) SHALL equal the OR of the grants.

REQ-009 rd_vld[i] SHALL be the registered copy of rd_gnt[i], so read latency is 1 cycle, and rd_data SHALL equal mem_rdata passthrough.

REQ-010 The FSM SHALL have two states, IDLE and OWNED, with registers owner (clog2(N_REQ) bits) and burst_cnt (clog2(MAX_BURST+1) bits).

REQ-011 In IDLE with no requests, no grant SHALL be issued and the state SHALL stay IDLE.

REQ-012 In IDLE with any request, the winner SHALL be the first requester found by round-robin search starting at rr_ptr, which is granted and moves the FSM to OWNED with burst_cnt=1.

REQ-013 In OWNED, if the owner still requests and burst_cnt<MAX_BURST, the owner SHALL be granted again and burst_cnt incremented.

REQ-014 In OWNED, if the owner drops req, or burst_cnt==MAX_BURST while another requester is pending, rr_ptr SHALL become owner+1 (mod N_REQ), wrapping N_RD to 0.
- In that same cycle a new round-robin winner SHALL be granted (no bubble), with burst_cnt=1.
- If no request is pending, the FSM SHALL go to IDLE.

REQ-015 At burst_cnt==MAX_BURST with only the owner requesting, the owner SHALL be re-granted and burst_cnt reset to 1, with no idle cycle.

REQ-016 Any requester with req held high SHALL be granted within N_RD*MAX_BURST+1 cycles.

Reset
REQ-017 While rstn=0 the block SHALL hold state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, rd_vld=0, with all grants and mem_ren/mem_wen low.

REQ-018 Assertion of rstn mid-operation SHALL drop any pending rd_vld immediately, and the first post-reset grant SHALL follow REQ-012 from rr_ptr=0.

Structure
REQ-019 Package ram_arb_pkg SHALL hold the state enum (IDLE, OWNED), N_REQ, the owner index type and the WR_IDX=N_RD constant.

REQ-020 The round-robin search SHALL be a combinational sub-module rr_arbiter with inputs req and ptr, and outputs one-hot gnt and idx.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then idle: all outputs 0 and no mem access for 20 cycles.
- rd_req=3'b111, wr_req=1 held, MAX_BURST=4: grant sequence is rd0 x4, rd1 x4, rd2 x4, wr x4, repeating; mem_ren/mem_wen are never both high.
- rd_req[1] pulsed alone at addr 0x10, memory preloaded 0x10=0xA5..: rd_gnt[1] is high the same cycle, rd_vld[1] is high the next cycle, and rd_data equals the preloaded word.
- Writer owns at burst_cnt=2 and drops wr_req while rd_req[0] is high: rd0 is granted in the same cycle and rr_ptr=0.
- Only rd2 requesting for 40 cycles: rd_gnt[2] is continuously high with burst_cnt wrapping 4->1.
- rstn deasserted while rd_gnt[0] is high: rd_vld[0]=0 the next cycle, and after release with all requesting, rd0 is granted first.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared FSM type and default sizing for the RAM port arbiter.
// The writer always sits at the index just past the last reader.
package ram_arb_pkg;

   localparam int NUM_RD  = 3;
   localparam int N_REQ   = NUM_RD + 1;
   localparam int WR_IDX  = NUM_RD;
   localparam int OWNER_W = $clog2(N_REQ);

   typedef logic [OWNER_W-1:0] owner_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: grants the first requester found
// starting at index ptr and wrapping around.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   logic          found;
   logic [IW-1:0] cand;

   always_comb begin
      // NOTE: every variable gets a default first, so no path can infer a latch.
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         cand = IW'((int'(ptr) + i) % N);
         if (!found && req[cand]) begin
            gnt[cand] = 1'b1;
            idx       = cand;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates N_RD readers and one writer onto a single-port RAM with
// same-cycle grants, bounded bursts and round-robin hand-over.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter  int N_RD           = NUM_RD,
   parameter  int AXI_WIDTH      = 128,
   parameter  int AXI_ADDR_WIDTH = 32,
   parameter  int MAX_BURST      = 16,
   localparam int LSB            = $clog2(AXI_WIDTH) - 3,
   localparam int AW             = AXI_ADDR_WIDTH - LSB,
   localparam int SW             = AXI_WIDTH / 8
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [N_RD-1:0]           rd_req,
   input  logic [N_RD-1:0][AW-1:0]   rd_addr,
   output logic [N_RD-1:0]           rd_gnt,
   output logic [N_RD-1:0]           rd_vld,
   output logic [AXI_WIDTH-1:0]      rd_data,
   input  logic                      wr_req,
   input  logic [AW-1:0]             wr_addr,
   input  logic [AXI_WIDTH-1:0]      wr_data,
   input  logic [SW-1:0]             wr_strb,
   output logic                      wr_gnt,
   output logic                      mem_ren,
   output logic                      mem_wen,
   output logic [AW-1:0]             mem_addr,
   output logic [AXI_WIDTH-1:0]      mem_wdata,
   output logic [SW-1:0]             mem_strb,
   input  logic [AXI_WIDTH-1:0]      mem_rdata
);

   localparam int            NQ      = N_RD + 1;
   localparam int            OW      = $clog2(NQ);
   localparam int            CW      = $clog2(MAX_BURST + 1);
   localparam logic [OW-1:0] WR_I    = OW'(N_RD);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   state_e        state_q, state_d;
   logic [OW-1:0] owner_q, owner_d;
   logic [OW-1:0] rr_ptr_q, rr_ptr_d;
   logic [CW-1:0] burst_q, burst_d;
   logic [N_RD-1:0] rd_vld_q;

   logic [NQ-1:0] req_vec;
   logic [NQ-1:0] owner_oh;
   logic [NQ-1:0] win_gnt;
   logic [NQ-1:0] fsm_gnt;
   logic [NQ-1:0] gnt;
   logic [OW-1:0] win_idx;
   logic [OW-1:0] owner_nxt;
   logic [OW-1:0] search_ptr;
   logic          any_req;
   logic          owner_req;
   logic          others_req;

   assign req_vec    = {wr_req, rd_req};
   assign any_req    = |req_vec;
   assign owner_oh   = NQ'(1) << owner_q;
   assign owner_req  = |(req_vec & owner_oh);
   assign others_req = |(req_vec & ~owner_oh);
   assign owner_nxt  = (owner_q == WR_I) ? '0 : owner_q + 1'b1;

   // A releasing owner hands over starting just past itself in the same cycle.
   assign search_ptr = (state_q == OWNED) ? owner_nxt : rr_ptr_q;

   rr_arbiter #(.N(NQ)) u_rr (
      .req (req_vec),
      .ptr (search_ptr),
      .gnt (win_gnt),
      .idx (win_idx)
   );

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      burst_d  = burst_q;
      fsm_gnt  = '0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               fsm_gnt = win_gnt;
               owner_d = win_idx;
               burst_d = CNT_ONE;
               state_d = OWNED;
            end
         end
         OWNED: begin
            if (owner_req && (burst_q < CNT_MAX)) begin
               fsm_gnt = owner_oh;
               burst_d = burst_q + 1'b1;
            end else if (owner_req && !others_req) begin
               fsm_gnt = owner_oh;
               burst_d = CNT_ONE;
            end else begin
               rr_ptr_d = owner_nxt;
               if (any_req) begin
                  fsm_gnt = win_gnt;
                  owner_d = win_idx;
                  burst_d = CNT_ONE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Grants are forced low for the whole time reset is held, not just at the edge.
   assign gnt    = rstn ? fsm_gnt : '0;
   assign rd_gnt = gnt[N_RD-1:0];
   assign wr_gnt = gnt[N_RD];

   assign mem_ren   = |rd_gnt;
   assign mem_wen   = wr_gnt;
   assign mem_wdata = wr_gnt ? wr_data : '0;
   assign mem_strb  = wr_gnt ? wr_strb : '0;

   always_comb begin
      mem_addr = wr_gnt ? wr_addr : '0;
      for (int i = 0; i < N_RD; i++) begin
         if (rd_gnt[i]) mem_addr = rd_addr[i];
      end
   end

   assign rd_vld  = rd_vld_q;
   assign rd_data = mem_rdata;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         burst_q  <= '0;
         rd_vld_q <= '0;
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values.
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         burst_q  <= burst_d;
         rd_vld_q <= rd_gnt;
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomised and directed bench for ram_port_arbiter against a
// requester-level reference model and a behavioural RAM.
module tb_ram_port_arbiter;

   localparam int NR    = 3;
   localparam int NQ    = NR + 1;
   localparam int DW    = 128;
   localparam int AW    = 32 - ($clog2(DW) - 3);
   localparam int SW    = DW / 8;
   localparam int MAXB  = 4;
   localparam int BOUND = NR * MAXB + 1;

   logic                  clk;
   logic                  rstn;
   logic [NR-1:0]         rd_req;
   logic [NR-1:0][AW-1:0] rd_addr;
   logic [NR-1:0]         rd_gnt;
   logic [NR-1:0]         rd_vld;
   logic [DW-1:0]         rd_data;
   logic                  wr_req;
   logic [AW-1:0]         wr_addr;
   logic [DW-1:0]         wr_data;
   logic [SW-1:0]         wr_strb;
   logic                  wr_gnt;
   logic                  mem_ren;
   logic                  mem_wen;
   logic [AW-1:0]         mem_addr;
   logic [DW-1:0]         mem_wdata;
   logic [SW-1:0]         mem_strb;
   logic [DW-1:0]         mem_rdata;

   ram_port_arbiter #(.MAX_BURST(MAXB)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_gnt    (rd_gnt),
      .rd_vld    (rd_vld),
      .rd_data   (rd_data),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_strb   (wr_strb),
      .wr_gnt    (wr_gnt),
      .mem_ren   (mem_ren),
      .mem_wen   (mem_wen),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_strb  (mem_strb),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port RAM driven by the DUT, with a preload port.
   logic [DW-1:0] mem [32];
   logic          pre_en;
   logic [4:0]    pre_addr;
   logic [DW-1:0] pre_data;

   always @(posedge clk) begin
      if (pre_en) begin
         mem[pre_addr] <= pre_data;
      end else begin
         if (mem_wen)
            for (int b = 0; b < SW; b++)
               if (mem_strb[b]) mem[mem_addr[4:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
         if (mem_ren) mem_rdata <= mem[mem_addr[4:0]];
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: who holds the port, how long, and where the next search starts.
   logic [DW-1:0] ref_mem [32];
   int            m_holder;
   int            m_run;
   int            m_from;
   logic [NR-1:0] exp_vld;
   logic [DW-1:0] exp_rdata;

   task automatic model_reset();
      m_holder  = -1;
      m_run     = 0;
      m_from    = 0;
      exp_vld   = '0;
      exp_rdata = '0;
   endtask

   function automatic int model_pick(input logic [NQ-1:0] r);
      int start;
      if (m_holder >= 0 && r[m_holder] &&
          (m_run < MAXB || r == (NQ'(1) << m_holder))) return m_holder;
      start = (m_holder >= 0) ? (m_holder + 1) % NQ : m_from;
      for (int k = 0; k < NQ; k++)
         if (r[(start + k) % NQ]) return (start + k) % NQ;
      return -1;
   endfunction

   task automatic model_commit(input int g);
      exp_vld = '0;
      if (g >= 0 && g < NR) begin
         exp_vld[g] = 1'b1;
         exp_rdata  = ref_mem[rd_addr[g][4:0]];
      end else if (g == NR) begin
         for (int b = 0; b < SW; b++)
            if (wr_strb[b]) ref_mem[wr_addr[4:0]][8*b +: 8] = wr_data[8*b +: 8];
      end
      if (m_holder >= 0 && g == m_holder) begin
         m_run = (m_run == MAXB) ? 1 : m_run + 1;
      end else begin
         if (m_holder >= 0) m_from = (m_holder + 1) % NQ;
         m_holder = g;
         m_run    = (g >= 0) ? 1 : 0;
      end
   endtask

   function automatic int obs_idx();
      case ({wr_gnt, rd_gnt})
         4'b0000: return -1;
         4'b0001: return 0;
         4'b0010: return 1;
         4'b0100: return 2;
         4'b1000: return 3;
         default: return 99;
      endcase
   endfunction

   // One clock: called just after a falling edge with inputs already driven.
   task automatic cycle(input string tag, output int g);
      logic [NQ-1:0] r;
      int            e;
      r = {wr_req, rd_req};
      #1;
      e = model_pick(r);
      g = obs_idx();
      check({tag, "/gnt"}, DW'(g), DW'(e));
      check({tag, "/ren"}, DW'(mem_ren), DW'(e >= 0 && e < NR));
      check({tag, "/wen"}, DW'(mem_wen), DW'(e == NR));
      if (e >= 0 && e < NR) check({tag, "/raddr"}, DW'(mem_addr), DW'(rd_addr[e]));
      if (e == NR) begin
         check({tag, "/waddr"}, DW'(mem_addr), DW'(wr_addr));
         check({tag, "/wdata"}, mem_wdata, wr_data);
         check({tag, "/wstrb"}, DW'(mem_strb), DW'(wr_strb));
      end
      check({tag, "/vld"}, DW'(rd_vld), DW'(exp_vld));
      if (exp_vld != '0) check({tag, "/rdata"}, rd_data, exp_rdata);
      model_commit(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input int cycles);
      rstn = 1'b0;
      #1;
      check("rst/gnt", DW'({wr_gnt, rd_gnt}), '0);
      check("rst/mem", DW'({mem_ren, mem_wen}), '0);
      check("rst/vld", DW'(rd_vld), '0);
      repeat (cycles) @(negedge clk);
      check("rst/hold", DW'({wr_gnt, rd_gnt, rd_vld}), '0);
      rstn = 1'b1;
      model_reset();
   endtask

   function automatic logic [DW-1:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic new_fields(input int i);
      if (i < NR) begin
         rd_addr[i] = AW'($urandom_range(0, 31));
      end else begin
         wr_addr = AW'($urandom_range(0, 31));
         wr_data = rand_word();
         wr_strb = SW'($urandom);
      end
   endtask

   int g;
   int pend [NQ];
   int wt   [NQ];

   initial begin
      rstn     = 1'b0;
      rd_req   = '0;
      rd_addr  = '0;
      wr_req   = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      wr_strb  = '0;
      pre_en   = 1'b0;
      pre_addr = '0;
      pre_data = '0;
      model_reset();
      @(negedge clk);

      for (int a = 0; a < 32; a++) begin
         pre_en      = 1'b1;
         pre_addr    = 5'(a);
         pre_data    = (a == 16) ? {SW{8'hA5}} : rand_word();
         ref_mem[a]  = pre_data;
         @(negedge clk);
      end
      pre_en = 1'b0;

      // Requests asserted while reset is held must not be granted.
      rd_req = '1;
      wr_req = 1'b1;
      do_reset(2);

      // Idle after reset: no grants and no memory traffic.
      rd_req = '0;
      wr_req = 1'b0;
      for (int k = 0; k < 20; k++) cycle("idle", g);

      // Everyone requesting: four-deep bursts in strict round-robin order.
      do_reset(1);
      rd_addr = {AW'(2), AW'(1), AW'(0)};
      wr_addr = AW'(3);
      wr_data = rand_word();
      wr_strb = '1;
      rd_req  = '1;
      wr_req  = 1'b1;
      for (int k = 0; k < 32; k++) begin
         cycle("all", g);
         check("all/seq", DW'(g), DW'((k / MAXB) % NQ));
      end

      // Single read of a preloaded word: same-cycle grant, one-cycle data.
      rd_req = '0;
      wr_req = 1'b0;
      do_reset(1);
      rd_addr[1] = AW'(16);
      rd_req     = 3'b010;
      cycle("pulse", g);
      check("pulse/idx", DW'(g), DW'(1));
      rd_req = '0;
      check("pulse/vld1", DW'(rd_vld), DW'(3'b010));
      check("pulse/data", rd_data, {SW{8'hA5}});
      cycle("pulse_after", g);

      // Writer gives up mid-burst: hand-over restarts the search at reader 0.
      do_reset(1);
      wr_addr = AW'(5);
      wr_data = rand_word();
      wr_strb = '1;
      wr_req  = 1'b1;
      cycle("wdrop", g);
      rd_req = 3'b011;
      cycle("wdrop", g);
      check("wdrop/owner", DW'(g), DW'(NR));
      wr_req = 1'b0;
      cycle("wdrop", g);
      check("wdrop/next", DW'(g), DW'(0));

      // Lone requester keeps the port across burst wrap-around.
      rd_req = 3'b100;
      for (int k = 0; k < 40; k++) begin
         cycle("solo", g);
         check("solo/idx", DW'(g), DW'(2));
      end

      // Reset while reader 0 is granted drops its pending valid.
      rd_req = '0;
      do_reset(1);
      rd_req = '1;
      wr_req = 1'b1;
      cycle("rstmid", g);
      #1;
      check("rstmid/gnt0", DW'(rd_gnt[0]), DW'(1));
      check("rstmid/vld0", DW'(rd_vld[0]), DW'(1));
      rstn = 1'b0;
      #1;
      check("rstmid/vldclr", DW'(rd_vld), '0);
      check("rstmid/gntclr", DW'({wr_gnt, rd_gnt}), '0);
      @(posedge clk);
      #1;
      check("rstmid/vldnext", DW'(rd_vld), '0);
      @(negedge clk);
      rstn = 1'b1;
      model_reset();
      cycle("rstmid", g);
      check("rstmid/first", DW'(g), DW'(0));

      // Random traffic: requests held until granted, bounded waiting.
      rd_req = '0;
      wr_req = 1'b0;
      do_reset(1);
      for (int i = 0; i < NQ; i++) begin
         pend[i] = 0;
         wt[i]   = 0;
      end
      for (int t = 0; t < 2000; t++) begin
         for (int i = 0; i < NQ; i++)
            if (pend[i] == 0 && $urandom_range(0, 2) == 0) begin
               pend[i] = 1;
               new_fields(i);
            end
         for (int i = 0; i < NR; i++) rd_req[i] = (pend[i] != 0);
         wr_req = (pend[NR] != 0);
         cycle("rand", g);
         for (int i = 0; i < NQ; i++)
            if (pend[i] != 0) begin
               wt[i] = (g == i) ? 0 : wt[i] + 1;
               check("rand/wait", DW'(wt[i] <= BOUND), DW'(1));
            end
         if (g >= 0 && g < NQ) begin
            if ($urandom_range(0, 3) == 0) pend[g] = 0;
            else new_fields(g);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
